// File: rtl/step_sequencer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : step_sequencer_ctrl
// Brief    : Tick-driven 16-step pattern sequencer issuing notes over valid/ready
//            and owning per-note gate timing.
// Revision : 1.0 - initial release
// ============================================================================
module step_sequencer_ctrl #(
    parameter int STEPS  = 16,
    parameter int NOTE_W = 7,
    parameter int TICK_W = 8
) (
    input  logic                     CLK_50_MHz,
    input  logic                     reset,
    input  logic                     CLK_100Hz,
    input  logic                     start,
    input  logic                     stop,
    input  logic [TICK_W-1:0]        ticks_per_step,
    input  logic [TICK_W-1:0]        gate_ticks,
    input  logic                     wr_en,
    input  logic [$clog2(STEPS)-1:0] wr_addr,
    input  logic [NOTE_W-1:0]        wr_note,
    input  logic                     wr_rest,
    output logic [NOTE_W-1:0]        note_out,
    output logic                     note_valid,
    input  logic                     note_ready,
    output logic                     gate,
    output logic [$clog2(STEPS)-1:0] step_idx,
    output logic                     busy
);

    localparam int         c_IDX_W    = $clog2(STEPS);
    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_LOAD     = 2'd1;
    localparam logic [1:0] c_WAIT_ACK = 2'd2;
    localparam logic [1:0] c_RUN      = 2'd3;

    logic [1:0]         r_state, w_state_nxt;
    logic               r_busy;
    logic               r_prev;
    logic               w_tick;
    logic [TICK_W-1:0]  r_tick_cnt, w_tick_cnt_nxt;
    logic [TICK_W-1:0]  r_tps_l, w_tps_l_nxt;
    logic [TICK_W-1:0]  r_gate_l, w_gate_l_nxt;
    logic [TICK_W-1:0]  w_tps_sample;
    logic [TICK_W:0]    w_cnt_inc;
    logic [c_IDX_W-1:0] r_step_idx, w_step_nxt;
    logic [NOTE_W-1:0]  r_note_out, w_note_nxt;
    logic               r_note_valid, w_valid_nxt;
    logic               r_gate, w_gate_nxt;
    logic               w_enter_run;
    logic [NOTE_W:0]    w_entry;

    // Entry layout: {rest, note}
    logic [NOTE_W:0]    r_mem [STEPS];

    assign w_tick     = CLK_100Hz & ~r_prev;
    assign note_out   = r_note_out;
    assign note_valid = r_note_valid;
    assign gate       = r_gate;
    assign step_idx   = r_step_idx;
    assign busy       = r_busy;

    always_ff @(posedge CLK_50_MHz or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STEPS; i++) begin
                r_mem[i] <= {1'b1, {NOTE_W{1'b0}}};
            end
        end else if (wr_en) begin
            r_mem[wr_addr] <= {wr_rest, wr_note};
        end
    end

    always_ff @(posedge CLK_50_MHz or posedge reset) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_busy       <= 1'b0;
            r_prev       <= 1'b0;
            r_tick_cnt   <= '0;
            r_tps_l      <= '0;
            r_gate_l     <= '0;
            r_step_idx   <= '0;
            r_note_out   <= '0;
            r_note_valid <= 1'b0;
            r_gate       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_busy       <= (w_state_nxt != c_IDLE);
            r_prev       <= CLK_100Hz;
            r_tick_cnt   <= w_tick_cnt_nxt;
            r_tps_l      <= w_tps_l_nxt;
            r_gate_l     <= w_gate_l_nxt;
            r_step_idx   <= w_step_nxt;
            r_note_out   <= w_note_nxt;
            r_note_valid <= w_valid_nxt;
            r_gate       <= w_gate_nxt;
        end
    end

    always_comb begin
        w_entry        = r_mem[r_step_idx];
        w_cnt_inc      = {1'b0, r_tick_cnt} + 1'b1;
        w_tps_sample   = (ticks_per_step == '0) ? TICK_W'(1) : ticks_per_step;
        w_state_nxt    = r_state;
        w_step_nxt     = r_step_idx;
        w_note_nxt     = r_note_out;
        w_valid_nxt    = r_note_valid;
        w_gate_nxt     = r_gate;
        w_tick_cnt_nxt = r_tick_cnt;
        w_tps_l_nxt    = r_tps_l;
        w_gate_l_nxt   = r_gate_l;
        w_enter_run    = 1'b0;

        case (r_state)
            c_IDLE: begin
                w_valid_nxt = 1'b0;
                w_gate_nxt  = 1'b0;
                if (start) begin
                    w_state_nxt = c_LOAD;
                    w_step_nxt  = '0;
                end
            end
            c_LOAD: begin
                w_gate_nxt = 1'b0;
                if (w_entry[NOTE_W]) begin
                    w_valid_nxt = 1'b0;
                    w_enter_run = 1'b1;
                end else begin
                    w_state_nxt = c_WAIT_ACK;
                    w_note_nxt  = w_entry[NOTE_W-1:0];
                    w_valid_nxt = 1'b1;
                end
            end
            c_WAIT_ACK: begin
                // Ticks here are intentionally ignored; the step clock restarts on RUN entry
                if (note_ready) begin
                    w_valid_nxt = 1'b0;
                    w_gate_nxt  = 1'b1;
                    w_enter_run = 1'b1;
                end
            end
            c_RUN: begin
                if (r_gate_l == '0) begin
                    w_gate_nxt = 1'b0;
                end
                if (w_tick) begin
                    w_tick_cnt_nxt = w_cnt_inc[TICK_W-1:0];
                    if (w_cnt_inc == {1'b0, r_gate_l}) begin
                        w_gate_nxt = 1'b0;
                    end
                    if (w_cnt_inc == {1'b0, r_tps_l}) begin
                        w_gate_nxt  = 1'b0;
                        w_step_nxt  = r_step_idx + 1'b1;
                        w_state_nxt = c_LOAD;
                    end
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase

        if (w_enter_run) begin
            w_state_nxt    = c_RUN;
            w_tick_cnt_nxt = '0;
            w_tps_l_nxt    = w_tps_sample;
            w_gate_l_nxt   = gate_ticks;
        end

        if (stop) begin
            w_state_nxt = c_IDLE;
            w_valid_nxt = 1'b0;
            w_gate_nxt  = 1'b0;
            w_step_nxt  = r_step_idx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_step_sequencer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_step_sequencer_ctrl
// Brief    : Directed self-checking bench for step_sequencer_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_step_sequencer_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       CLK_100Hz;
    logic       start;
    logic       stop;
    logic [7:0] ticks_per_step;
    logic [7:0] gate_ticks;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [6:0] wr_note;
    logic       wr_rest;
    logic [6:0] note_out;
    logic       note_valid;
    logic       note_ready;
    logic       gate;
    logic [3:0] step_idx;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_hs     = 0;
    int q5[$];

    always #10 clk = ~clk;

    step_sequencer_ctrl #(.STEPS(16), .NOTE_W(7), .TICK_W(8)) dut (
        .CLK_50_MHz     (clk),
        .reset          (reset),
        .CLK_100Hz      (CLK_100Hz),
        .start          (start),
        .stop           (stop),
        .ticks_per_step (ticks_per_step),
        .gate_ticks     (gate_ticks),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_note        (wr_note),
        .wr_rest        (wr_rest),
        .note_out       (note_out),
        .note_valid     (note_valid),
        .note_ready     (note_ready),
        .gate           (gate),
        .step_idx       (step_idx),
        .busy           (busy)
    );

    // Handshake log
    always @(posedge clk) begin
        if (note_valid && note_ready) begin
            n_hs++;
            if (step_idx == 4'd5) q5.push_back(int'(note_out));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick();
        @(negedge clk);
        CLK_100Hz = 1'b1;
        @(negedge clk);
        CLK_100Hz = 1'b0;
    endtask

    task automatic wr(input int addr, input int note, input logic rest);
        wr_en   = 1'b1;
        wr_addr = 4'(addr);
        wr_note = 7'(note);
        wr_rest = rest;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    // Called at the negedge right after LOAD entry of a note step, ready high
    task automatic play_note_step(input string tag, input int note, input int idx);
        @(negedge clk);
        check({tag, "_valid"}, note_valid, 1);
        check({tag, "_note"}, note_out, note);
        check({tag, "_idx"}, step_idx, idx);
        @(negedge clk);
        check({tag, "_gate_on"}, gate, 1);
        check({tag, "_valid_off"}, note_valid, 0);
    endtask

    initial begin
        int bad;
        int v0;
        int v1;
        bit wrote;

        reset = 1'b1; CLK_100Hz = 1'b0; start = 1'b0; stop = 1'b0;
        ticks_per_step = 8'd4; gate_ticks = 8'd2;
        wr_en = 1'b0; wr_addr = '0; wr_note = '0; wr_rest = 1'b0; note_ready = 1'b0;
        cyc(2);
        check("rst_valid", note_valid, 0);
        check("rst_gate", gate, 0);
        check("rst_busy", busy, 0);
        check("rst_idx", step_idx, 0);
        reset = 1'b0;
        @(negedge clk);

        // Async reset during WAIT_ACK
        wr(0, 33, 1'b0);
        pulse_start();
        check("load_busy", busy, 1);
        @(negedge clk);
        check("wa_valid", note_valid, 1);
        check("wa_note", note_out, 33);
        @(negedge clk);
        #3 reset = 1'b1;
        #1;
        check("arst_valid", note_valid, 0);
        check("arst_note", note_out, 0);
        check("arst_busy", busy, 0);
        check("arst_gate", gate, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        note_ready = 1'b1;
        pulse_start();
        @(negedge clk);
        check("cleared_rest_valid", note_valid, 0);
        check("cleared_rest_busy", busy, 1);
        @(negedge clk);
        check("cleared_rest_valid2", note_valid, 0);
        pulse_stop();
        check("cleared_stop_busy", busy, 0);

        // Basic playback
        wr(0, 60, 1'b0);
        wr(1, 62, 1'b0);
        wr(2, 64, 1'b0);
        ticks_per_step = 8'd4; gate_ticks = 8'd2;
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            play_note_step("basic", 60 + 2 * i, i);
            tick();
            check("basic_gate_t1", gate, 1);
            tick();
            check("basic_gate_t2", gate, 0);
            tick();
            tick();
            check("basic_advance", step_idx, i + 1);
        end
        v0 = n_hs;
        for (int s = 3; s < 16; s++) begin
            @(negedge clk);
            repeat (4) tick();
        end
        check("rest_no_valid", n_hs, v0);
        check("wrap_idx", step_idx, 0);
        play_note_step("wrap", 60, 0);
        repeat (4) tick();
        play_note_step("wrap1", 62, 1);

        // Start while busy, then stop in RUN with gate high
        pulse_start();
        check("busy_start_gate", gate, 1);
        check("busy_start_idx", step_idx, 1);
        @(negedge clk);
        check("busy_start_valid", note_valid, 0);
        check("busy_start_idx2", step_idx, 1);
        pulse_stop();
        check("stop_gate", gate, 0);
        check("stop_busy", busy, 0);
        check("stop_valid", note_valid, 0);
        check("stop_idx_held", step_idx, 1);

        // start and stop together in IDLE
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check("ss_busy", busy, 0);
        check("ss_idx", step_idx, 1);
        @(negedge clk);
        check("ss_busy2", busy, 0);
        check("ss_valid", note_valid, 0);

        // Backpressure
        note_ready = 1'b0;
        pulse_start();
        @(negedge clk);
        check("bp_valid", note_valid, 1);
        check("bp_note", note_out, 60);
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            if (!(note_valid === 1'b1 && note_out == 7'd60 && gate === 1'b0 && busy === 1'b1)) bad++;
            CLK_100Hz = (i == 100 || i == 250 || i == 400);
            @(negedge clk);
        end
        CLK_100Hz = 1'b0;
        check("bp_stable", bad, 0);
        check("bp_idx", step_idx, 0);
        note_ready = 1'b1;
        @(negedge clk);
        check("bp_gate_on", gate, 1);
        check("bp_valid_off", note_valid, 0);
        repeat (3) tick();
        check("bp_idx_after3", step_idx, 0);
        check("bp_gate_after3", gate, 0);
        tick();
        check("bp_idx_after4", step_idx, 1);
        pulse_stop();

        // ticks_per_step = 0 and gate_ticks = 0
        ticks_per_step = 8'd0; gate_ticks = 8'd0;
        pulse_start();
        play_note_step("tps0", 60, 0);
        @(negedge clk);
        check("g0_pulse", gate, 0);
        tick();
        check("tps0_adv1", step_idx, 1);
        play_note_step("tps0b", 62, 1);
        tick();
        check("tps0_adv2", step_idx, 2);
        pulse_stop();

        // gate_ticks beyond step length
        ticks_per_step = 8'd4; gate_ticks = 8'd9;
        pulse_start();
        play_note_step("g9", 60, 0);
        repeat (3) tick();
        check("g9_gate_t3", gate, 1);
        tick();
        check("g9_gate_boundary", gate, 0);
        check("g9_idx", step_idx, 1);
        @(negedge clk);
        check("g9_next_valid", note_valid, 1);
        check("g9_next_gate", gate, 0);
        pulse_stop();

        // Write/read collision at step 5
        wr(5, 50, 1'b0);
        ticks_per_step = 8'd1; gate_ticks = 8'd1;
        q5.delete();
        wrote = 1'b0;
        pulse_start();
        for (int i = 0; i < 2000 && q5.size() < 2; i++) begin
            if (!wrote && busy && step_idx == 4'd5) begin
                wr_en = 1'b1; wr_addr = 4'd5; wr_note = 7'd70; wr_rest = 1'b0;
                wrote = 1'b1;
            end else begin
                wr_en = 1'b0;
            end
            CLK_100Hz = (i % 4 == 0);
            @(negedge clk);
        end
        wr_en = 1'b0;
        CLK_100Hz = 1'b0;
        v0 = (q5.size() > 0) ? q5[0] : -1;
        v1 = (q5.size() > 1) ? q5[1] : -1;
        check("coll_count", q5.size(), 2);
        check("coll_first_old", v0, 50);
        check("coll_second_new", v1, 70);
        pulse_stop();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
